// File: rtl/s2p_pkg.sv
// s2p_pkg: shared definitions for the serial-to-parallel framing controller.
//   state_e  - framing FSM states (hunt for sync, collect payload, re-check sync)
//   BIT_DEF  - default word / sync-word width
//   SYNC_DEF - default sync pattern, MSB received first
package s2p_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_e;

    localparam int              BIT_DEF  = 10;
    localparam logic [9:0]      SYNC_DEF = 10'h1B5;

endpackage

// File: rtl/s2p_frame_ctrl_shreg.sv
// s2p_shreg: serial shift register with a saturating sample counter.
//   clk, rst_n : clock, async active-low reset
//   en_i       : sample strobe; shifts din_i in and advances the counter
//   clr_i      : zeroes the sample counter (shift contents are kept)
//   din_i      : serial input bit
//   sh_o       : last BIT samples, newest in bit 0
//   cnt_o      : samples since last clear, saturating at BIT-1
module s2p_shreg #(
    parameter int BIT = 10,
    parameter int CW  = $clog2(BIT)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           clr_i,
    input  logic           din_i,
    output logic [BIT-1:0] sh_o,
    output logic [CW-1:0]  cnt_o
);

    localparam logic [CW-1:0] CNT_SAT = CW'(BIT - 1);

    logic [BIT-1:0] sh_q;
    logic [CW-1:0]  cnt_q;

    // Shift register and saturating counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (en_i) begin
                sh_q <= {sh_q[BIT-2:0], din_i};
            end
            if (clr_i) begin
                cnt_q <= '0;
            end else if (en_i && (cnt_q != CNT_SAT)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign sh_o  = sh_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/s2p_frame_ctrl.sv
// s2p_frame_ctrl: hunts a sync word in a serial stream, then emits
// FRAME_WORDS payload words per frame, re-checking sync between frames
// with a flywheel of MISS_MAX misses.
//   clk, rst_n        : clock, async active-low reset
//   din, din_en       : serial bit and its sample strobe
//   dout, dout_sof    : payload word (first bit in MSB) and start-of-frame flag
//   dout_valid/ready  : single-entry registered output handshake
//   locked            : sync confirmed at least once since last hunt
//   overflow, ovf_clr : sticky dropped-word flag and its clear
module s2p_frame_ctrl
    import s2p_pkg::*;
#(
    parameter int             BIT         = BIT_DEF,
    parameter logic [BIT-1:0] SYNC_WORD   = BIT'(SYNC_DEF),
    parameter int             FRAME_WORDS = 4,
    parameter int             MISS_MAX    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           din,
    input  logic           din_en,
    output logic [BIT-1:0] dout,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic           dout_sof,
    output logic           locked,
    output logic           overflow,
    input  logic           ovf_clr
);

    localparam int CW  = $clog2(BIT);
    localparam int WCW = $clog2(FRAME_WORDS + 1);
    localparam int MCW = $clog2(MISS_MAX + 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);
    localparam logic [MCW-1:0] MISS_LAST = MCW'(MISS_MAX - 1);

    state_e          state_q;
    logic [WCW-1:0]  word_cnt_q;
    logic [MCW-1:0]  miss_cnt_q;
    logic            locked_q;
    logic            word_done_q;
    logic            word_sof_q;
    logic [BIT-1:0]  dout_q;
    logic            dout_valid_q;
    logic            dout_sof_q;
    logic            overflow_q;

    logic [BIT-1:0]  sh_s;
    logic [CW-1:0]   cnt_s;
    logic [BIT-1:0]  word_s;
    logic            last_bit_s;
    logic            step_s;
    logic            drop_s;

    s2p_shreg #(.BIT(BIT), .CW(CW)) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (din_en),
        .clr_i (step_s),
        .din_i (din),
        .sh_o  (sh_s),
        .cnt_o (cnt_s)
    );

    // Detect the sample that finishes a word, a sync check, or a hunt match.
    always_comb begin
        word_s     = {sh_s[BIT-2:0], din};
        last_bit_s = 1'b0;
        case (state_q)
            // In HUNT the counter saturates, so BIT_LAST means a full window.
            ST_HUNT:    last_bit_s = (cnt_s == BIT_LAST) && (word_s == SYNC_WORD);
            ST_PAYLOAD: last_bit_s = (cnt_s == BIT_LAST);
            ST_CHECK:   last_bit_s = (cnt_s == BIT_LAST);
            default:    last_bit_s = 1'b0;
        endcase
        step_s = din_en && last_bit_s;
        // A completed word finds the register full and not draining.
        drop_s = word_done_q && dout_valid_q && !dout_ready;
    end

    // Framing FSM: state, word/miss counters, lock flag, word-complete pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            word_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            word_done_q <= 1'b0;
            word_sof_q  <= 1'b0;
        end else begin
            // The finished word sits in the shift register for one cycle;
            // the output stage picks it up on the next edge.
            word_done_q <= step_s && (state_q == ST_PAYLOAD);
            word_sof_q  <= (word_cnt_q == '0);
            if (step_s) begin
                case (state_q)
                    ST_HUNT: begin
                        state_q    <= ST_PAYLOAD;
                        word_cnt_q <= '0;
                    end
                    ST_PAYLOAD: begin
                        if (word_cnt_q == WORD_LAST) begin
                            state_q    <= ST_CHECK;
                            word_cnt_q <= '0;
                        end else begin
                            word_cnt_q <= word_cnt_q + WCW'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (word_s == SYNC_WORD) begin
                            miss_cnt_q <= '0;
                            locked_q   <= 1'b1;
                            state_q    <= ST_PAYLOAD;
                        end else if (miss_cnt_q == MISS_LAST) begin
                            miss_cnt_q <= '0;
                            locked_q   <= 1'b0;
                            state_q    <= ST_HUNT;
                        end else begin
                            // Flywheel: tolerate the miss, keep framing.
                            miss_cnt_q <= miss_cnt_q + MCW'(1);
                            state_q    <= ST_PAYLOAD;
                        end
                    end
                    default: begin
                        state_q    <= ST_HUNT;
                        word_cnt_q <= '0;
                        miss_cnt_q <= '0;
                        locked_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Single-entry output register with sticky overflow (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (word_done_q && !drop_s) begin
                dout_q       <= sh_s;
                dout_sof_q   <= word_sof_q;
                dout_valid_q <= 1'b1;
            end else if (dout_ready) begin
                dout_valid_q <= 1'b0;
            end
            if (drop_s) begin
                overflow_q <= 1'b1;
            end else if (ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_sof   = dout_sof_q;
    assign locked     = locked_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl with a scoreboard of expected words.
module tb_s2p_frame_ctrl;

    localparam int         BIT  = 10;
    localparam logic [9:0] SYNC = 10'h1B5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din = 1'b0;
    logic          din_en = 1'b0;
    logic [BIT-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic          dout_sof;
    logic          locked;
    logic          overflow;
    logic          ovf_clr = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [BIT:0] exp_q[$];

    s2p_frame_ctrl #(
        .BIT(BIT), .SYNC_WORD(SYNC), .FRAME_WORDS(2), .MISS_MAX(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_sof(dout_sof), .locked(locked), .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit1(input logic b);
        din = b;
        din_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) bit1(w[i]);
    endtask

    task automatic word_toggle(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) begin
            bit1(w[i]);
            din_en = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        din_en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_word(input logic sof, input logic [9:0] w);
        exp_q.push_back({sof, w});
    endtask

    // Scoreboard: every accepted word must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                assert (0) else begin
                    bad++;
                    $error("FAIL unexpected_word observed=%0h expected=none", {dout_sof, dout});
                end
            end else begin
                chk("sb_word", {21'd0, dout_sof, dout}, {21'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", {22'd0, dout}, 32'd0);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_sof", {31'd0, dout_sof}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: hunt, two payload words, latency of one edge after last bit
        for (int i = 0; i < 7; i++) bit1(1'($urandom_range(1, 0)));
        word(SYNC);
        expect_word(1'b1, 10'h201);
        word(10'h201);
        chk("lat_pre", {31'd0, dout_valid}, 32'd0);
        idle(1);
        chk("lat_post", {31'd0, dout_valid}, 32'd1);
        chk("w0_data", {22'd0, dout}, 32'h201);
        chk("w0_sof", {31'd0, dout_sof}, 32'd1);
        expect_word(1'b0, 10'h0FF);
        word(10'h0FF);
        chk("unlocked_pre_check", {31'd0, locked}, 32'd0);

        // 2: good sync check raises locked on its last bit
        for (int i = 9; i >= 1; i--) bit1(SYNC[i]);
        chk("locked_before_last", {31'd0, locked}, 32'd0);
        bit1(SYNC[0]);
        chk("locked_on_last", {31'd0, locked}, 32'd1);
        expect_word(1'b1, 10'h155);
        word(10'h155);
        expect_word(1'b0, 10'h2AA);
        word(10'h2AA);

        // 3: one miss keeps framing, second miss drops to hunt
        word(10'h000);
        chk("flywheel_locked", {31'd0, locked}, 32'd1);
        expect_word(1'b1, 10'h0F0);
        word(10'h0F0);
        expect_word(1'b0, 10'h30C);
        word(10'h30C);
        chk("flywheel_locked2", {31'd0, locked}, 32'd1);
        word(10'h000);
        chk("lost_lock", {31'd0, locked}, 32'd0);
        word(10'h155);
        word(10'h2AA);
        idle(1);
        chk("hunt_no_output", {31'd0, dout_valid}, 32'd0);
        word(SYNC);
        chk("rehunt_unlocked", {31'd0, locked}, 32'd0);
        expect_word(1'b1, 10'h3E1);
        word(10'h3E1);
        expect_word(1'b0, 10'h01F);
        word(10'h01F);
        word(SYNC);
        chk("relock", {31'd0, locked}, 32'd1);

        // 4: back-pressure -> hold first, drop second, overflow, clear
        dout_ready = 1'b0;
        expect_word(1'b1, 10'h111);
        word(10'h111);
        word(10'h222);
        idle(1);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("held_valid", {31'd0, dout_valid}, 32'd1);
        chk("held_data", {22'd0, dout}, 32'h111);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        dout_ready = 1'b1;
        idle(1);
        chk("drained", {31'd0, dout_valid}, 32'd0);
        word(SYNC);
        chk("lock_after_ovf", {31'd0, locked}, 32'd1);

        // 5: din_en toggling every cycle during payload
        expect_word(1'b1, 10'h2C3);
        word_toggle(10'h2C3);
        expect_word(1'b0, 10'h13C);
        word_toggle(10'h13C);
        word(SYNC);

        // 6: reset in the middle of a payload word
        for (int i = 0; i < 5; i++) bit1(1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", {22'd0, dout}, 32'd0);
        chk("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("mid_rst_locked", {31'd0, locked}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) bit1(1'b1);
        idle(2);
        chk("partial_dropped", {31'd0, dout_valid}, 32'd0);
        word(SYNC);
        expect_word(1'b1, 10'h0C3);
        word(10'h0C3);
        expect_word(1'b0, 10'h3C0);
        word(10'h3C0);
        idle(4);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s2p_frame_ctrl.md
# s2p_frame_ctrl

Framing controller for the serial-to-parallel path. It hunts a fixed sync word in the serial bit stream and, once synced, assembles a fixed number of payload words per frame. It re-verifies sync between frames, with a flywheel tolerance for missed sync words. Completed words go downstream through a registered valid/ready output with overflow detection. It sits between the serial input pin and the word-level consumer that currently takes raw s2p output.

## Interface
- `BIT`, 10, word width and sync-word width
- `SYNC_WORD`, 10'h1B5, sync pattern, MSB received first
- `FRAME_WORDS`, 4, payload words per frame (≥1)
- `MISS_MAX`, 2, consecutive sync misses that drop lock (≥1)
- `clk` in 1: sole clock; all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `din` in 1: serial data, sampled when `din_en`=1
- `din_en` in 1: bit strobe; 0 freezes framing state
- `dout` out BIT: payload word, first received bit in `dout[BIT-1]`
- `dout_valid` out 1: `dout` holds an unaccepted word
- `dout_ready` in 1: consumer accepts when `dout_valid`&`dout_ready`
- `dout_sof` out 1: qualifies `dout`; 1 on the first word of a frame
- `locked` out 1: sync confirmed at least once since last HUNT
- `overflow` out 1: sticky; a completed word was dropped
- `ovf_clr` in 1: clears `overflow`

## Operation
- Reset values: `dout`=0, `dout_valid`=0, `dout_sof`=0, `locked`=0, `overflow`=0, state HUNT, bit/word/miss counters 0, shift register 0.
- The shift register updates as sh ← {sh[BIT-2:0], din} on every `din_en` sample.
- **HUNT**
  - Match when the last BIT samples equal `SYNC_WORD` and at least BIT samples have been taken since entering HUNT.
  - On match, go to PAYLOAD on the same edge with bit count 0 and word count 0.
- **PAYLOAD**
  - Every BIT samples completes a word, which is offered to the output.
  - The first word of the frame carries sof=1.
  - After `FRAME_WORDS` words, go to CHECK.
- **CHECK**
  - Collect BIT samples and compare them to `SYNC_WORD`.
  - Match: miss count ← 0, `locked` ← 1, go to PAYLOAD.
  - Mismatch: miss count +1. If it reaches `MISS_MAX`, go to HUNT with `locked` ← 0 and miss count ← 0. Otherwise go to PAYLOAD (flywheel); `locked` is unchanged.
- **Output register** (single entry)
  - On word completion, if the register is empty or being accepted this cycle, load `dout`/`dout_sof` and set `dout_valid`.
  - Otherwise drop the word and set `overflow`. Framing continues unaffected.
- `overflow`: set has priority over `ovf_clr` in the same cycle.
- `din_en`=0 holds the state, counters, and shift register. The output handshake still operates.

## Timing
- Bit-to-output latency: `dout_valid` rises on the clock edge after the edge that samples the word's last bit.
- `dout`/`dout_sof` are stable while `dout_valid`=1 and unaccepted.
- `dout_valid` falls on the edge after acceptance, unless a new word loads on that same edge, in which case it stays 1.
- HUNT→PAYLOAD and CHECK→next transitions take effect on the edge that samples the final sync bit. No idle cycles are inserted.
- `locked` updates on that same edge.
- Reset asserted mid-frame clears everything immediately. Partially collected bits are discarded; hunting resumes after release.

## Structure
- Package `s2p_pkg` holds:
  - state encoding constants HUNT/PAYLOAD/CHECK
  - default `BIT`
  - default `SYNC_WORD`
- Sub-module `s2p_shreg`: BIT-wide shift register plus saturating sample counter with `en`/`clr` inputs. The controller instantiates it once and owns the FSM, word/miss counters, and output register.

## Test plan
Bench parameters: BIT=10, SYNC_WORD=10'h1B5, FRAME_WORDS=2, MISS_MAX=2. `din_en`=1 and `dout_ready`=1 unless noted.

1. Random 7 bits, then 0110110101, then 1000000001, then 0011111111 → two words 10'h201 (sof=1) then 10'h0FF (sof=0). Each `dout_valid` appears one cycle after its 10th bit.
2. Scenario 1 followed by a correct sync and a word 10'h155 → `locked` rises on the last sync bit; next `dout`=10'h155 with sof=1.
3. After lock, corrupt one CHECK word (10'h000) → flywheel: the following frame is still output and `locked`=1. Corrupt the next CHECK as well → return to HUNT, `locked`=0, no further words until a new 0110110101.
4. `dout_ready`=0 across two word completions → the first word is held, the second is dropped, `overflow`=1. Pulse `ovf_clr` → `overflow`=0.
5. Toggle `din_en` 0/1 every cycle during PAYLOAD → same words as scenario 1, with latency doubled.
6. Assert `rst_n`=0 at bit 5 of a payload word → all outputs 0 immediately. After release, the block hunts and the partial word is never output.
